// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared encodings for the two-port memory arbiter.
//   state_e : arbiter FSM states (IDLE arbitrates, WAIT has one access outstanding)
//   owner_e : which requester owns the outstanding access
//   CNT_W   : width of the latency and starvation counters (covers 1..15)
package mem_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch port, data port and memory port of the
// arbiter.
//   slave  : arbiter view (takes requests and read data, drives grants,
//            responses, stalls and the memory strobe)
//   master : environment view (pipeline stages plus the memory model)
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_stall_o;
    logic              d_req_i;
    logic              d_we_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic              d_gnt_o;
    logic              d_rvalid_o;
    logic [DATA_W-1:0] d_rdata_o;
    logic              d_stall_o;
    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_rdata_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o, if_stall_o,
        output d_gnt_o, d_rvalid_o, d_rdata_o, d_stall_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_rdata_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o, if_stall_o,
        input  d_gnt_o, d_rvalid_o, d_rdata_o, d_stall_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/mem_arbiter_starve_cnt.sv
// starve_cnt: saturating counter of consecutive arbitrations lost by fetch.
//   clk, rst : clock, synchronous active-high reset
//   inc      : count one more lost arbitration (holds at STARVE_MAX)
//   clr      : clear to zero, wins over inc
//   sat      : counter has reached STARVE_MAX
//   cnt      : current count
module starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic             sat,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] cnt_r;
    logic             sat_s;

    assign sat_s = (cnt_r == CNT_W'(STARVE_MAX));

    // Counter register: clear has priority, increment stops at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc && !sat_s) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign sat = sat_s;
    assign cnt = cnt_r;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency single-ported memory between the
// instruction-fetch port and the data (load/store) port, one access at a time.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_arbiter_if.slave carrying
//              if_*  fetch request/grant/response/stall
//              d_*   data request/grant/response/stall (d_we_i=1 is a store)
//              mem_* memory strobe, write enable, address, write data, read data
// Grants are combinational in IDLE; the response pulses MEM_LAT+1 cycles later.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    state_e            state_r;
    state_e            state_s;
    logic [CNT_W-1:0]  cnt_r;
    owner_e            owner_r;
    logic              owner_we_r;
    logic [DATA_W-1:0] if_rdata_r;
    logic [DATA_W-1:0] d_rdata_r;
    logic              if_rvalid_r;
    logic              d_rvalid_r;

    logic              arb_ok_s;
    logic              if_win_s;
    logic              d_win_s;
    logic              grant_s;
    logic              done_s;
    logic              starve_inc_s;
    logic              starve_clr_s;
    logic              starve_sat_s;
    logic [CNT_W-1:0]  starve_cnt_s;

    // Arbitration: data (older instruction) wins unless fetch has starved.
    always_comb begin
        arb_ok_s = 1'b0;
        if_win_s = 1'b0;
        d_win_s  = 1'b0;
        if (!rst && (state_r == ST_IDLE)) begin
            arb_ok_s = 1'b1;
            if_win_s = bus.if_req_i & (~bus.d_req_i | starve_sat_s);
            d_win_s  = bus.d_req_i & ~if_win_s;
        end else begin
            arb_ok_s = 1'b0;
        end
    end

    assign grant_s = if_win_s | d_win_s;
    assign done_s  = (state_r == ST_WAIT) && (cnt_r == {CNT_W{1'b0}});

    // Fetch loses only when it asked in an arbitration cycle and was not chosen.
    assign starve_inc_s = arb_ok_s & bus.if_req_i & ~if_win_s;
    assign starve_clr_s = if_win_s | ~bus.if_req_i;

    starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk (clk),
        .rst (rst),
        .inc (starve_inc_s),
        .clr (starve_clr_s),
        .sat (starve_sat_s),
        .cnt (starve_cnt_s)
    );

    // Memory port mux from the winner; idle memory port is driven to zero.
    always_comb begin
        bus.mem_en_o    = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_addr_o  = {ADDR_W{1'b0}};
        bus.mem_wdata_o = {DATA_W{1'b0}};
        if (d_win_s) begin
            bus.mem_en_o    = 1'b1;
            bus.mem_we_o    = bus.d_we_i;
            bus.mem_addr_o  = bus.d_addr_i;
            bus.mem_wdata_o = bus.d_wdata_i;
        end else if (if_win_s) begin
            bus.mem_en_o    = 1'b1;
            bus.mem_addr_o  = bus.if_addr_i;
        end else begin
            bus.mem_en_o    = 1'b0;
        end
    end

    // Next-state logic: WAIT runs until the latency counter reaches zero.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (done_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, owner and latency counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            owner_r    <= OWN_IF;
            owner_we_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if (grant_s) begin
                owner_r    <= d_win_s ? OWN_D : OWN_IF;
                owner_we_r <= d_win_s & bus.d_we_i;
                cnt_r      <= CNT_W'(MEM_LAT - 1);
            end else if ((state_r == ST_WAIT) && !done_s) begin
                cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Response capture: one-cycle rvalid for the owner; stores leave d_rdata alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rvalid_r <= 1'b0;
            d_rvalid_r  <= 1'b0;
            if_rdata_r  <= {DATA_W{1'b0}};
            d_rdata_r   <= {DATA_W{1'b0}};
        end else begin
            if_rvalid_r <= done_s && (owner_r == OWN_IF);
            d_rvalid_r  <= done_s && (owner_r == OWN_D);
            if (done_s && (owner_r == OWN_IF)) begin
                if_rdata_r <= bus.mem_rdata_i;
            end else begin
                if_rdata_r <= if_rdata_r;
            end
            if (done_s && (owner_r == OWN_D) && !owner_we_r) begin
                d_rdata_r <= bus.mem_rdata_i;
            end else begin
                d_rdata_r <= d_rdata_r;
            end
        end
    end

    assign bus.if_gnt_o    = if_win_s;
    assign bus.d_gnt_o     = d_win_s;
    assign bus.if_rvalid_o = if_rvalid_r;
    assign bus.d_rvalid_o  = d_rvalid_r;
    assign bus.if_rdata_o  = if_rdata_r;
    assign bus.d_rdata_o   = d_rdata_r;
    assign bus.if_stall_o  = ~rst & ((bus.if_req_i & ~if_win_s) |
                                     ((state_r == ST_WAIT) && (owner_r == OWN_IF)));
    assign bus.d_stall_o   = ~rst & ((bus.d_req_i & ~d_win_s) |
                                     ((state_r == ST_WAIT) && (owner_r == OWN_D)));
endmodule
